// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE,
    ABORT
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_NOACK    = 2'b01,
    ERR_START_TO = 2'b10,
    ERR_XFER_TO  = 2'b11
  } ps2_err_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  function automatic int ps2_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line and only follows it after FILTER_LEN equal samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        filt  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out
// 8 data bits + odd parity + stop on device clocks, then sample the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000,
  parameter int FILTER_LEN     = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       rx_block,
  output logic       done,
  output logic [1:0] err
);
  localparam int CW = $clog2(ps2_max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT) + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XT_LAST  = CW'(XFER_TIMEOUT - 1);
  localparam logic [3:0]    STOP_CNT = 4'd9;

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          kd_q, kd_d;
  logic [1:0]    err_q, err_d;

  logic [1:0] line_raw, line_filt;
  logic       kclk_f, kdata_f, kclk_prev, fall;

  // Index 0 = kclk, index 1 = kdata.
  assign line_raw = {kdata_i, kclk_i};

  for (genvar g = 0; g < 2; g++) begin : g_filt
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (line_raw[g]),
      .filt (line_filt[g])
    );
  end

  assign kclk_f  = line_filt[0];
  assign kdata_f = line_filt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_prev <= 1'b1;
      fall      <= 1'b0;
    end else begin
      kclk_prev <= kclk_f;
      fall      <= kclk_prev & ~kclk_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      kd_q    <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      kd_q    <= kd_d;
      err_q   <= err_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    bit_d   = bit_q;
    shift_d = shift_q;
    kd_d    = kd_q;
    err_d   = err_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        kd_d  = 1'b0;
        cnt_d = '0;
        if (tx_valid) begin
          shift_d = {1'b1, ~^tx_data, tx_data};
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        // Start bit goes onto kdata one cycle before kclk is let go.
        if (cnt_q == INH_PRE) kd_d = 1'b1;
        if (cnt_q >= INH_LAST) begin
          kd_d    = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fall) begin
          kd_d    = ~shift_q[0];
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = 4'd1;
          cnt_d   = '0;
          state_d = DATA;
        end else if (cnt_q >= ST_LAST) begin
          kd_d    = 1'b0;
          err_d   = ERR_START_TO;
          state_d = ABORT;
        end
      end
      DATA: begin
        if (cnt_q >= XT_LAST) begin
          kd_d    = 1'b0;
          err_d   = ERR_XFER_TO;
          state_d = ABORT;
        end else if (fall) begin
          kd_d    = ~shift_q[0];
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == STOP_CNT) state_d = ACK;
        end
      end
      ACK: begin
        if (cnt_q >= XT_LAST) begin
          kd_d    = 1'b0;
          err_d   = ERR_XFER_TO;
          state_d = ABORT;
        end else if (fall) begin
          kd_d    = 1'b0;
          err_d   = kdata_f ? ERR_NOACK : ERR_OK;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        kd_d = 1'b0;
        if (kclk_f && kdata_f) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        kd_d    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        kd_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign rx_block = (state_q != IDLE);
  assign kclk_oe  = (state_q == INHIBIT);
  assign kdata_oe = kd_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus with a device BFM, a per-cycle
// timeline model of the host outputs, and frame/err/timing checks per transfer.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int IC = 20, ST = 400, XT = 2000, FL = 3, H = 12;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, kclk_oe, kdata_oe, rx_block, done;
  logic [1:0] err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       kclk_line, kdata_line;

  int npass = 0, ntot = 0;

  bit         m_busy = 1'b0;
  int         m_age = 0;
  int         done_cnt = 0, done_age = 0;
  logic [1:0] last_err = 2'b00;
  logic       done_kc = 1'b0, done_kd = 1'b0;

  assign kclk_line  = ~(kclk_oe | dev_clk_low);
  assign kdata_line = ~(kdata_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(IC), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .kclk_i(kclk_line), .kdata_i(kdata_line), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe),
    .rx_block(rx_block), .done(done), .err(err)
  );

  task automatic chk(input string name, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected 11-bit frame on the wire, start bit in [0], from counting ones.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return {1'b1, logic'(n % 2 == 0), d, 1'b0};
  endfunction

  // Transfer timeline: age 1..IC is the inhibit window, IC+1 is clock release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (tx_valid) begin
        m_busy <= 1'b1;
        m_age  <= 1;
      end
    end else if (done) begin
      m_busy <= 1'b0;
    end else if (m_age < 100000) begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_kclk_oe", int'(kclk_oe), 0);
      chk("rst_kdata_oe", int'(kdata_oe), 0);
      chk("rst_tx_ready", int'(tx_ready), 1);
      chk("rst_rx_block", int'(rx_block), 0);
      chk("rst_done", int'(done), 0);
    end else begin
      chk("rx_block", int'(rx_block), int'(m_busy));
      chk("tx_ready", int'(tx_ready), int'(!m_busy));
      chk("kclk_oe", int'(kclk_oe), int'(m_busy && m_age <= IC));
      if (m_busy && m_age <= IC + 1) chk("kdata_oe_start", int'(kdata_oe), int'(m_age >= IC));
      if (!m_busy) begin
        chk("idle_kdata_oe", int'(kdata_oe), 0);
        chk("idle_done", int'(done), 0);
      end
      if (done) begin
        done_cnt++;
        last_err = err;
        done_age = m_age;
        done_kc  = kclk_oe;
        done_kd  = kdata_oe;
      end
    end
  end

  // Device: waits for request-to-send, throws a 2-sample clock glitch, then clocks nf bits.
  task automatic dev_run(input int nf, input bit ack, output logic [10:0] fr);
    int w = 0;
    fr = '1;
    while (!(kclk_line && !kdata_line) && w < 300) begin
      wait_cyc(1);
      w++;
    end
    chk("dev_saw_request", int'(w < 300), 1);
    wait_cyc(8);
    dev_clk_low = 1'b1;
    wait_cyc(2);
    dev_clk_low = 1'b0;
    wait_cyc(10);
    fr[0] = kdata_line;
    for (int i = 1; i <= nf; i++) begin
      dev_clk_low = 1'b1;
      if (i == 11) dev_data_low = ack;
      wait_cyc(H);
      if (i <= 10) fr[i] = kdata_line;
      dev_clk_low = 1'b0;
      wait_cyc(H);
    end
    dev_data_low = 1'b0;
  endtask

  // mode: 0 ACK, 1 no ACK, 2 device silent, 3 device stops after 5 falls
  task automatic send(input logic [7:0] d, input int mode, input logic [1:0] exp_err,
                      input string tag, output logic [10:0] fr);
    int dc0, w;
    dc0 = done_cnt;
    fr = '1;
    tx_data = d; tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0; tx_data = 8'h55;
    wait_cyc(5);
    tx_valid = 1'b1;
    wait_cyc(3);
    tx_valid = 1'b0;
    if (mode == 0) dev_run(11, 1'b1, fr);
    else if (mode == 1) dev_run(11, 1'b0, fr);
    else if (mode == 3) dev_run(5, 1'b1, fr);
    w = 0;
    while (done_cnt == dc0 && w < 5000) begin
      wait_cyc(1);
      w++;
    end
    chk({tag, " done_once"}, done_cnt - dc0, 1);
    chk({tag, " err"}, int'(last_err), int'(exp_err));
    chk({tag, " lines_released_at_done"}, int'({done_kc, done_kd}), 0);
    if (mode <= 1) chk({tag, " frame"}, int'(fr), int'(frame_of(d)));
    if (mode == 2) chk({tag, " done_age"}, done_age, IC + 1 + ST);
    wait_cyc(10);
    chk({tag, " ready_after"}, int'(tx_ready), 1);
  endtask

  initial begin
    logic [10:0] fr;
    int dc0;
    #1 rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);

    chk("pin_frame_ED", int'(frame_of(8'hED)), 32'h7DA);
    chk("pin_par_00", int'(frame_of(8'h00) >> 9) & 1, 1);
    chk("pin_par_01", int'(frame_of(8'h01) >> 9) & 1, 0);

    send(PS2_CMD_SET_LEDS, 0, ERR_OK, "t1_ED", fr);
    chk("t1 data bits", int'(fr[8:1]), 32'hED);
    chk("t1 parity", int'(fr[9]), 1);
    chk("t1 start_stop", int'({fr[10], fr[0]}), 2);

    send(8'h3C, 1, ERR_NOACK, "t3_noack", fr);
    send(8'hA5, 2, ERR_START_TO, "t4_start_to", fr);
    send(8'h5A, 3, ERR_XFER_TO, "t5_xfer_to", fr);

    send(8'h00, 0, ERR_OK, "t2_00", fr);
    chk("t2 parity 00", int'(fr[9]), 1);
    send(PS2_CMD_RESET, 0, ERR_OK, "t2_FF", fr);
    chk("t2 parity FF", int'(fr[9]), 1);
    send(8'h01, 0, ERR_OK, "t2_01", fr);
    chk("t2 parity 01", int'(fr[9]), 0);

    dc0 = done_cnt;
    tx_data = 8'h00; tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
    dev_run(4, 1'b1, fr);
    chk("t6 pre kdata_oe", int'(kdata_oe), 1);
    chk("t6 pre rx_block", int'(rx_block), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 kclk_oe", int'(kclk_oe), 0);
    chk("t6 kdata_oe", int'(kdata_oe), 0);
    chk("t6 rx_block", int'(rx_block), 0);
    chk("t6 tx_ready", int'(tx_ready), 1);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("t6 no done", done_cnt - dc0, 0);
    send(PS2_CMD_RESET, 0, ERR_OK, "t6_after", fr);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
